jk_mode_register: RTL
=====================

Name: jk_mode_register

Overview:
- Parametrised WIDTH-bit register bank with per-bit JK flip-flop semantics and falling-edge clocking, extended with modulo up/down counting and parallel load.
- Serves as the general state element for small counters and flag banks in the design.
- Adds a terminal-count flag and a registered wrap pulse for cascading.

Parameters:
- WIDTH, 4, number of bits in Q; legal range 1..16.
- MODULO, 16, count modulus; legal range 2..2^WIDTH; the counter cycles over 0..MODULO-1.
- RESET_VAL, 0, value Q takes under reset; must be less than MODULO.

Ports:
- CLK  input  1  clock; all state updates occur on the falling edge.
- RESET_N  input  1  asynchronous active-low reset.
- EN  input  1  update enable; 0 holds all state.
- MODE  input  2  operating mode: 00 JK, 01 count up, 10 count down, 11 load.
- J  input  WIDTH  per-bit J inputs, used in JK mode only.
- K  input  WIDTH  per-bit K inputs, used in JK mode only.
- D  input  WIDTH  parallel load data, used in load mode only.
- Q  output  WIDTH  register state.
- TC  output  1  terminal count, combinational.
- OVF  output  1  registered one-cycle wrap pulse.

Behaviour:
Reset
- RESET_N low immediately forces Q=RESET_VAL and OVF=0, independent of CLK.
- While RESET_N is low, falling edges have no effect.
- The first update occurs on the first falling edge after RESET_N is sampled high.
- Asserting reset mid-operation discards any pending update.

Clocking and enable
- Single falling-edge always block; no other state is kept.
- EN=0 at a falling edge: Q holds and OVF is cleared to 0.

JK mode (00), each bit i independently
- {J[i],K[i]}=00: hold.
- 10: set to 1.
- 01: clear to 0.
- 11: toggle.
- MODULO is not applied; raw bit values are allowed, including values >= MODULO.
- OVF=0.

Count up (01)
- Q<MODULO-1: Q+1, OVF=0.
- Q=MODULO-1: Q becomes 0 and OVF=1 for one cycle.
- Q>=MODULO (only reachable via JK mode): Q becomes 0 and OVF=1.

Count down (10)
- Q>0 and Q<MODULO: Q-1, OVF=0.
- Q=0: Q becomes MODULO-1 and OVF=1 for one cycle.
- Q>=MODULO: Q becomes MODULO-1 and OVF=1.

Load (11)
- D<MODULO: Q=D.
- D>=MODULO: Q saturates to MODULO-1.
- OVF=0.

TC
- Combinational from MODE and Q; ignores EN.
- TC=1 when MODE=01 and Q>=MODULO-1, or when MODE=10 and Q==0 or Q>=MODULO. Otherwise TC=0.
- TC therefore predicts OVF for the next enabled edge.

Arithmetic
- All computation is WIDTH bits plus one guard bit; no intermediate truncation.
- MODULO=2^WIDTH gives natural binary wrap.

Latency
- Q and OVF change one falling edge after the inputs are sampled.
- Inputs must be stable around the falling edge.

Test Plan:
1. Async reset:
   - Stimulus: WIDTH=4, RESET_VAL=5; Q=9 from a load; RESET_N pulled low between edges.
   - Required: Q=5 and OVF=0 immediately; Q stays 5 across 3 falling edges while low.
2. JK mode:
   - Stimulus: from Q=4'b0101, apply J=4'b1100, K=4'b1010.
   - Required: bit3 toggles to 1, bit2 set to 1, bit1 cleared to 0, bit0 held at 1, so Q=4'b1101.
   - Follow-up: J=K=4'b0000 -> Q holds 4'b1101.
3. Modulo-10 up count:
   - Stimulus: MODULO=10, load 7, then MODE=01 for 4 edges.
   - Required: Q=8,9,0,1; TC=1 only while Q=9; OVF=1 exactly in the cycle after the 9->0 edge.
4. Down wrap and out-of-range recovery:
   - Stimulus: MODULO=10, count down from Q=1.
   - Required: Q=0 then 9, with OVF pulsing on the 0->9 edge.
   - Stimulus: JK-force Q=12, then count down.
   - Required: Q=9 with OVF=1.
5. Load saturation and enable hold:
   - Stimulus: MODULO=10, load D=14.
   - Required: Q=9.
   - Stimulus: EN=0 with MODE=01 for 3 edges.
   - Required: Q stays 9, OVF=0, TC=1.
6. Full binary wrap:
   - Stimulus: WIDTH=4, MODULO=16, count up from 15.
   - Required: Q=0 and OVF=1.
   - Stimulus: count down from 0.
   - Required: Q=15 and OVF=1.

Source files
------------

// File: rtl/jk_mode_register.sv
// WIDTH-bit falling-edge register bank: per-bit JK, modulo up/down count and
// saturating parallel load, with a terminal-count flag and a registered wrap pulse.

module jk_bit (
    input  logic q,
    input  logic j,
    input  logic k,
    output logic q_next
);
    always_comb begin
        unique case ({j, k})
            2'b00:   q_next = q;
            2'b10:   q_next = 1'b1;
            2'b01:   q_next = 1'b0;
            default: q_next = ~q;
        endcase
    end
endmodule

module jk_mode_register #(
    parameter int WIDTH     = 4,
    parameter int MODULO    = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);
    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_UP = 2'b01;
    localparam logic [1:0] MODE_DN = 2'b10;
    localparam logic [1:0] MODE_LD = 2'b11;

    // One guard bit so MODULO = 2^WIDTH is representable without truncation.
    localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0]   MOD_M1 = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RESET_VAL);

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;
    logic             up_wrap;
    logic             dn_wrap;

    assign q_ext = {1'b0, Q};
    assign d_ext = {1'b0, D};

    // Out-of-range values (only reachable through JK mode) wrap like the terminal value.
    assign up_wrap = (q_ext >= MOD_M1);
    assign dn_wrap = (q_ext == '0) || (q_ext >= MOD_W);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_bit u_bit (
            .q      (Q[i]),
            .j      (J[i]),
            .k      (K[i]),
            .q_next (jk_next[i])
        );
    end

    always_comb begin
        q_next   = Q;
        ovf_next = 1'b0;
        case (MODE)
            MODE_JK: q_next = jk_next;
            MODE_UP: begin
                if (up_wrap) begin
                    q_next   = '0;
                    ovf_next = 1'b1;
                end else begin
                    q_next = WIDTH'(q_ext + 1'b1);
                end
            end
            MODE_DN: begin
                if (dn_wrap) begin
                    q_next   = MOD_M1[WIDTH-1:0];
                    ovf_next = 1'b1;
                end else begin
                    q_next = WIDTH'(q_ext - 1'b1);
                end
            end
            MODE_LD: q_next = (d_ext >= MOD_W) ? MOD_M1[WIDTH-1:0] : D;
            default: q_next = Q;
        endcase
    end

    // Ignores EN on purpose: it predicts OVF for the next enabled edge.
    assign TC = ((MODE == MODE_UP) && up_wrap) || ((MODE == MODE_DN) && dn_wrap);

    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            Q   <= RST_Q;
            OVF <= 1'b0;
        end else if (EN) begin
            Q   <= q_next;
            OVF <= ovf_next;
        end else begin
            OVF <= 1'b0;
        end
    end
endmodule
